// File: rtl/mem_byte_sequencer_if.sv
// CPU-side load/store bus of the byte sequencer.
// The CPU drives the request fields; the sequencer returns rdata/ack/err.
interface mem_byte_sequencer_if #(
  parameter int ADDRESS_WIDTH = 32
);
  logic                     req;
  logic                     we;
  logic [1:0]               size;
  logic                     sext;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [31:0]              wdata;
  logic [31:0]              rdata;
  logic                     ack;
  logic                     err;

  modport master (
    output req, we, size, sext, addr, wdata,
    input  rdata, ack, err
  );

  modport slave (
    input  req, we, size, sext, addr, wdata,
    output rdata, ack, err
  );
endinterface

// File: rtl/mem_byte_sequencer.sv
// Splits CPU byte/half/word requests into sequential little-endian 8-bit RAM
// accesses, stalling on ram_busy, and returns an extended 32-bit load result.
module mem_byte_sequencer #(
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  mem_byte_sequencer_if.slave      cpu,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [7:0]               ram_din,
  output logic                     ram_we,
  input  logic [7:0]               ram_dout,
  input  logic                     ram_busy
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_XFER     = 3'd1,
    ST_CAPTURE  = 3'd2,
    ST_DONE     = 3'd3,
    ST_ERR      = 3'd4
  } state_e;

  function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] res;
    case (lane)
      2'd0:    res = word[7:0];
      2'd1:    res = word[15:8];
      2'd2:    res = word[23:16];
      2'd3:    res = word[31:24];
      default: res = 8'h00;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] data, input logic [1:0] sz,
                                              input logic sx);
    logic [31:0] res;
    case (sz)
      2'b00:   res = {{24{sx & data[7]}}, data[7:0]};
      2'b01:   res = {{16{sx & data[15]}}, data[15:0]};
      default: res = data;
    endcase
    return res;
  endfunction

  function automatic logic is_rejected(input logic [1:0] sz, input logic [1:0] low_addr);
    logic res;
    case (sz)
      2'b00:   res = 1'b0;
      2'b01:   res = low_addr[0];
      2'b10:   res = (low_addr != 2'b00);
      default: res = 1'b1;
    endcase
    return res;
  endfunction

  function automatic logic [1:0] last_index(input logic [1:0] sz);
    logic [1:0] res;
    case (sz)
      2'b00:   res = 2'd0;
      2'b01:   res = 2'd1;
      default: res = 2'd3;
    endcase
    return res;
  endfunction

  state_e                   state_q, state_d;
  logic                     we_q, we_d;
  logic [1:0]               size_q, size_d;
  logic                     sext_q, sext_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]              wdata_q, wdata_d;
  logic [1:0]               idx_q, idx_d;
  logic [1:0]               last_q, last_d;
  logic [31:0]              buf_q, buf_d;
  logic [31:0]              rdata_q, rdata_d;
  logic                     ack_q, ack_d;
  logic                     err_q, err_d;
  logic [ADDRESS_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]               ram_din_q, ram_din_d;
  logic                     ram_we_q, ram_we_d;
  logic [1:0]               idx_nxt_s;

  assign idx_nxt_s = idx_q + 2'd1;

  // Next-state and next-output logic; outputs are computed one cycle ahead so they register cleanly
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    sext_d     = sext_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    idx_d      = idx_q;
    last_d     = last_q;
    buf_d      = buf_q;
    rdata_d    = rdata_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_we_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu.req) begin
          we_d    = cpu.we;
          size_d  = cpu.size;
          sext_d  = cpu.sext;
          addr_d  = cpu.addr;
          wdata_d = cpu.wdata;
          idx_d   = 2'd0;
          last_d  = last_index(cpu.size);
          if (is_rejected(cpu.size, cpu.addr[1:0])) begin
            state_d = ST_ERR;
            ack_d   = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d    = ST_XFER;
            ram_addr_d = cpu.addr;
            ram_we_d   = cpu.we;
            ram_din_d  = cpu.wdata[7:0];
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (ram_busy) begin
          state_d = ST_CAPTURE;
        end else begin
          if (!we_q) begin
            case (idx_q)
              2'd0:    buf_d[7:0]   = ram_dout;
              2'd1:    buf_d[15:8]  = ram_dout;
              2'd2:    buf_d[23:16] = ram_dout;
              2'd3:    buf_d[31:24] = ram_dout;
              default: buf_d        = buf_q;
            endcase
          end else begin
            buf_d = buf_q;
          end
          if (idx_q == last_q) begin
            state_d = ST_DONE;
            ack_d   = 1'b1;
            if (!we_q) begin
              rdata_d = load_extend(buf_d, size_q, sext_q);
            end else begin
              rdata_d = rdata_q;
            end
          end else begin
            // Address wraps naturally modulo 2^ADDRESS_WIDTH
            state_d    = ST_XFER;
            idx_d      = idx_nxt_s;
            ram_addr_d = addr_q + ADDRESS_WIDTH'(idx_nxt_s);
            ram_we_d   = we_q;
            ram_din_d  = byte_lane(wdata_q, idx_nxt_s);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      sext_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'h0000_0000;
      idx_q      <= 2'd0;
      last_q     <= 2'd0;
      buf_q      <= 32'h0000_0000;
      rdata_q    <= 32'h0000_0000;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= 8'h00;
      ram_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      size_q     <= size_d;
      sext_q     <= sext_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      buf_q      <= buf_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ram_we_q   <= ram_we_d;
    end
  end

  assign cpu.rdata = rdata_q;
  assign cpu.ack   = ack_q;
  assign cpu.err   = err_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign ram_we    = ram_we_q;

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Scoreboard bench for mem_byte_sequencer: requests push expected results,
// a negedge monitor pops and compares them on each ack.
module tb_mem_byte_sequencer;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [7:0]  ram_dout;
  logic        ram_busy;
  logic [7:0]  mem [256];
  int          cyc = 0;
  int          wcount = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        sbq [$];

  mem_byte_sequencer_if #(.ADDRESS_WIDTH(32)) bus ();

  mem_byte_sequencer #(.ADDRESS_WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu      (bus),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout),
    .ram_busy (ram_busy)
  );

  always #5 clk = ~clk;

  // Byte-wide RAM model: combinational read, write on the clock edge
  assign ram_dout = mem[ram_addr[7:0]];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_we) begin
      mem[ram_addr[7:0]] <= ram_din;
      wcount <= wcount + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Monitor: every ack pops one expected result
  always @(negedge clk) begin
    exp_t e;
    if (bus.ack === 1'b1) begin
      if (sbq.size() == 0) begin
        check_val("spurious_ack", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        check_val("rdata", bus.rdata, e.rdata);
        check_val("err", {31'd0, bus.err}, {31'd0, e.err});
        check_val("latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end else if (bus.err === 1'b1) begin
      check_val("err_without_ack", 32'd1, 32'd0);
    end
  end

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sx, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_lat, input int busy_at, input int busy_len);
    exp_t e;
    int   wc0;
    int   nbytes;
    @(negedge clk);
    bus.req   = 1'b1;
    bus.we    = w;
    bus.size  = sz;
    bus.sext  = sx;
    bus.addr  = a;
    bus.wdata = wd;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.acc   = cyc;
    e.lat   = exp_lat;
    sbq.push_back(e);
    wc0 = wcount;
    for (int k = 1; k <= 60 && sbq.size() != 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.req = 1'b0;
        if (!exp_err) check_val("xfer_addr", ram_addr, a);
      end
      if (busy_len > 0 && k == busy_at) ram_busy = 1'b1;
      if (busy_len > 0 && k == busy_at + busy_len) ram_busy = 1'b0;
    end
    if (sbq.size() != 0) begin
      check_val("ack_timeout", 32'd1, 32'd0);
      sbq.delete();
    end
    ram_busy = 1'b0;
    @(negedge clk);
    nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    check_val("ram_writes", 32'(wcount - wc0), (exp_err || !w) ? 32'd0 : 32'(nbytes));
  endtask

  task automatic reset_mid_store();
    int wc0;
    @(negedge clk);
    bus.req   = 1'b1;
    bus.we    = 1'b1;
    bus.size  = 2'b10;
    bus.sext  = 1'b0;
    bus.addr  = 32'h30;
    bus.wdata = 32'h1122_3344;
    wc0 = wcount;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) bus.req = 1'b0;
    end
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_rdata", bus.rdata, 32'h0);
    check_val("rst_ack", {31'd0, bus.ack}, 32'h0);
    check_val("rst_err", {31'd0, bus.err}, 32'h0);
    check_val("rst_ram_we", {31'd0, ram_we}, 32'h0);
    check_val("rst_ram_din", {24'd0, ram_din}, 32'h0);
    check_val("rst_ram_addr", ram_addr, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check_val("rst_writes", 32'(wcount - wc0), 32'd2);
    check_val("rst_mem30", {24'd0, mem[8'h30]}, 32'h44);
    check_val("rst_mem31", {24'd0, mem[8'h31]}, 32'h33);
    check_val("rst_mem32", {24'd0, mem[8'h32]}, 32'h00);
    check_val("rst_mem33", {24'd0, mem[8'h33]}, 32'h00);
  endtask

  initial begin
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.size  = 2'b00;
    bus.sext  = 1'b0;
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;
    ram_busy  = 1'b0;
    reset     = 1'b0;
    repeat (3) @(negedge clk);
    check_val("init_rdata", bus.rdata, 32'h0);
    check_val("init_ack", {31'd0, bus.ack}, 32'h0);
    check_val("init_err", {31'd0, bus.err}, 32'h0);
    check_val("init_ram_we", {31'd0, ram_we}, 32'h0);
    check_val("init_ram_din", {24'd0, ram_din}, 32'h0);
    check_val("init_ram_addr", ram_addr, 32'h0);
    reset = 1'b1;

    // word store/load round trip
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 9, 0, 0);
    check_val("mem10", {24'd0, mem[8'h10]}, 32'hEF);
    check_val("mem11", {24'd0, mem[8'h11]}, 32'hBE);
    check_val("mem12", {24'd0, mem[8'h12]}, 32'hAD);
    check_val("mem13", {24'd0, mem[8'h13]}, 32'hDE);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 9, 0, 0);

    // byte load extension
    do_req(1'b1, 2'b00, 1'b0, 32'h20, 32'h0000_0080, 32'hDEAD_BEEF, 1'b0, 3, 0, 0);
    do_req(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 32'hFFFF_FF80, 1'b0, 3, 0, 0);
    do_req(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 32'h0000_0080, 1'b0, 3, 0, 0);

    // rejected requests leave rdata alone
    do_req(1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 32'h0000_0080, 1'b1, 1, 0, 0);
    do_req(1'b1, 2'b10, 1'b0, 32'h22, 32'h1234_5678, 32'h0000_0080, 1'b1, 1, 0, 0);
    do_req(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 32'h0000_0080, 1'b1, 1, 0, 0);

    // three busy cycles on the second byte
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 12, 4, 3);
    do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'hFFFF_DEAD, 1'b0, 5, 0, 0);

    // reset in the middle of a word store
    do_req(1'b1, 2'b10, 1'b0, 32'h30, 32'h0, 32'hFFFF_DEAD, 1'b0, 9, 0, 0);
    reset_mid_store();
    do_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h0000_3344, 1'b0, 9, 0, 0);

    // top-of-address-space behaviour
    do_req(1'b0, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0000_3344, 1'b1, 1, 0, 0);
    do_req(1'b1, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'h0000_005A, 32'h0000_3344, 1'b0, 3, 0, 0);
    do_req(1'b1, 2'b00, 1'b0, 32'h0, 32'h0000_00A5, 32'h0000_3344, 1'b0, 3, 0, 0);
    do_req(1'b0, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0000_005A, 1'b0, 3, 0, 0);
    do_req(1'b0, 2'b00, 1'b1, 32'h0, 32'h0, 32'hFFFF_FFA5, 1'b0, 3, 0, 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
